// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: owner codes, FSM states,
// grant-vector bit positions and the starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_D    = 2'd2,
    OWN_F    = 2'd3
  } owner_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Bit positions inside the one-hot grant vector
  localparam int unsigned GNT_LD = 2;
  localparam int unsigned GNT_D  = 1;
  localparam int unsigned GNT_F  = 0;

  // Wide enough for STARVE_MAX up to 15
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave: the arbiter's view; master: the core/loader/memory environment.
interface mem_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned N  = 32
);

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [N-1:0]  ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [N-1:0]  d_wdata;
  logic          d_gnt;
  logic          d_rvalid;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;

  logic [N-1:0]  rdata;
  logic          core_stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  f_req, f_addr,
    input  mem_rdata,
    output ld_gnt, ld_rvalid, d_gnt, d_rvalid, f_gnt, f_rvalid,
    output rdata, core_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output f_req, f_addr,
    output mem_rdata,
    input  ld_gnt, ld_rvalid, d_gnt, d_rvalid, f_gnt, f_rvalid,
    input  rdata, core_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_prio.sv
// Combinational winner select: loader > data > fetch, with the starved
// fetch overriding data. RUN with ld_req pending grants nothing (bubble).
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  state_t     state,
  input  logic       ld_req,
  input  logic       d_req,
  input  logic       f_req,
  input  logic       starve_hit,
  output logic [2:0] gnt,
  output owner_t     owner
);

  // Pick at most one winner for this cycle
  always_comb begin
    gnt   = '0;
    owner = OWN_NONE;
    case (state)
      ST_RUN: begin
        if (!ld_req) begin
          if (f_req && starve_hit) begin
            gnt[GNT_F] = 1'b1;
            owner      = OWN_F;
          end else if (d_req) begin
            gnt[GNT_D] = 1'b1;
            owner      = OWN_D;
          end else if (f_req) begin
            gnt[GNT_F] = 1'b1;
            owner      = OWN_F;
          end
        end
      end
      ST_LOAD: begin
        if (ld_req) begin
          gnt[GNT_LD] = 1'b1;
          owner       = OWN_LD;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch, data access and
// the host program loader. Grants are combinational; read data returns one
// cycle later, tagged by the owner recorded at grant time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 10,
  parameter int unsigned N          = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t                state;
  state_t                state_nxt;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  starve_hit;
  logic [2:0]            gnt_raw;
  logic [2:0]            gnt;
  owner_t                win_owner;
  owner_t                owner_q;
  logic                  win_we;
  logic [AW-1:0]         sel_addr;
  logic [N-1:0]          sel_wdata;
  logic [N-1:0]          rdata_q;

  assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));

  mem_arb_prio u_prio (
    .state      (state),
    .ld_req     (bus.ld_req),
    .d_req      (bus.d_req),
    .f_req      (bus.f_req),
    .starve_hit (starve_hit),
    .gnt        (gnt_raw),
    .owner      (win_owner)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next state: enter LOAD on a loader request, leave when it drops
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (bus.ld_req)  state_nxt = ST_LOAD;
      ST_LOAD: if (!bus.ld_req) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs: gated grants, memory port mux, read strobes, core stall
  always_comb begin
    gnt       = rst ? 3'b000 : gnt_raw;
    sel_addr  = '0;
    sel_wdata = '0;
    win_we    = 1'b0;
    if (gnt[GNT_LD]) begin
      sel_addr  = bus.ld_addr;
      sel_wdata = bus.ld_wdata;
      win_we    = bus.ld_we;
    end else if (gnt[GNT_D]) begin
      sel_addr  = bus.d_addr;
      sel_wdata = bus.d_wdata;
      win_we    = bus.d_we;
    end else if (gnt[GNT_F]) begin
      sel_addr  = bus.f_addr;
    end
    bus.ld_gnt    = gnt[GNT_LD];
    bus.d_gnt     = gnt[GNT_D];
    bus.f_gnt     = gnt[GNT_F];
    bus.mem_en    = |gnt;
    bus.mem_we    = win_we;
    bus.mem_addr  = sel_addr;
    bus.mem_wdata = sel_wdata;
    bus.ld_rvalid = (owner_q == OWN_LD);
    bus.d_rvalid  = (owner_q == OWN_D);
    bus.f_rvalid  = (owner_q == OWN_F);
    // Memory data is already registered inside the memory, so the valid
    // cycle forwards it directly; rdata_q holds it for later cycles.
    bus.rdata      = (owner_q != OWN_NONE) ? bus.mem_rdata : rdata_q;
    bus.core_stall = (state == ST_LOAD)
                   | (bus.ld_req & (state == ST_RUN))
                   | (bus.d_req & ~gnt[GNT_D])
                   | (bus.f_req & ~gnt[GNT_F]);
  end

  // Fetch starvation counter, saturating at STARVE_MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((state == ST_LOAD) || !bus.f_req || gnt[GNT_F]) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Owner of the read issued this cycle; writes and idle cycles record NONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    owner_q <= OWN_NONE;
    else if ((|gnt) && !win_we) owner_q <= win_owner;
    else                        owner_q <= OWN_NONE;
  end

  // Hold the last delivered read word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      rdata_q <= '0;
    else if (owner_q != OWN_NONE) rdata_q <= bus.mem_rdata;
  end

endmodule
